// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 neighbourhood windows: two line buffers feed a 3x3 shift array.
// A window is emitted only for interior centres, one clock after its newest pixel is accepted.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iPixelValid,
  input  logic              iSof,
  input  logic [DATA_W-1:0] iv8Pixel,
  output logic [DATA_W-1:0] ov8Pixel_a,
  output logic [DATA_W-1:0] ov8Pixel_b,
  output logic [DATA_W-1:0] ov8Pixel_c,
  output logic [DATA_W-1:0] ov8Pixel_d,
  output logic [DATA_W-1:0] ov8Pixel_fij,
  output logic [DATA_W-1:0] ov8Pixel_e,
  output logic [DATA_W-1:0] ov8Pixel_f,
  output logic [DATA_W-1:0] ov8Pixel_g,
  output logic [DATA_W-1:0] ov8Pixel_h,
  output logic              oDataValid,
  output logic              oSow,
  output logic              oEol
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]     col, colCur;
  logic [RW-1:0]     row, rowCur;
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb2 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1Rd, lb2Rd;
  // win[0] is row r-2, win[2] is row r; column 2 is the newest
  logic [DATA_W-1:0] win [3][3];
  logic              winHit;

  // A qualified start-of-frame overrides the counters for the pixel it marks.
  assign colCur = iSof ? '0 : col;
  assign rowCur = iSof ? '0 : row;
  assign lb1Rd  = lb1[colCur];
  assign lb2Rd  = lb2[colCur];
  assign winHit = (rowCur >= ROW_TWO) && (colCur >= COL_TWO);

  // Line RAMs carry no reset; the row gate keeps stale contents from ever reaching the output.
  always_ff @(posedge iClk) begin
    if (iPixelValid) begin
      lb2[colCur] <= lb1Rd;
      lb1[colCur] <= iv8Pixel;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      col          <= '0;
      row          <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
      ov8Pixel_a   <= '0;
      ov8Pixel_b   <= '0;
      ov8Pixel_c   <= '0;
      ov8Pixel_d   <= '0;
      ov8Pixel_fij <= '0;
      ov8Pixel_e   <= '0;
      ov8Pixel_f   <= '0;
      ov8Pixel_g   <= '0;
      ov8Pixel_h   <= '0;
      oDataValid   <= 1'b0;
      oSow         <= 1'b0;
      oEol         <= 1'b0;
    end else begin
      oDataValid <= 1'b0;
      oSow       <= 1'b0;
      oEol       <= 1'b0;
      if (iPixelValid) begin
        if (colCur == COL_LAST) begin
          col <= '0;
          row <= (rowCur == ROW_LAST) ? '0 : rowCur + 1'b1;
        end else begin
          col <= colCur + 1'b1;
          row <= rowCur;
        end
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb2Rd;
        win[1][2] <= lb1Rd;
        win[2][2] <= iv8Pixel;
        // Taps load only for real windows so they hold across non-window pixels and gaps.
        if (winHit) begin
          ov8Pixel_a   <= win[0][1];
          ov8Pixel_b   <= win[0][2];
          ov8Pixel_c   <= lb2Rd;
          ov8Pixel_d   <= win[1][1];
          ov8Pixel_fij <= win[1][2];
          ov8Pixel_e   <= lb1Rd;
          ov8Pixel_f   <= win[2][1];
          ov8Pixel_g   <= win[2][2];
          ov8Pixel_h   <= iv8Pixel;
          oDataValid   <= 1'b1;
          oSow         <= (rowCur == ROW_TWO) && (colCur == COL_TWO);
          oEol         <= (colCur == COL_LAST);
        end
      end
    end
  end

endmodule
